axis_id_demux: RTL and testbench
================================

# axis_id_demux

Routes one AXI-Stream into `SLAVE_NUM` outputs, using the source/destination index carried in `tuser`. It sits directly downstream of the round-robin join arbiter and consumes the merged stream, so each beat can be steered back to a per-channel consumer. Routing is decided on the first beat of each packet and held until `tlast`. Packets whose index is out of range are dropped and counted. The input is buffered by a 2-entry skid buffer and every output is registered, so the block sustains one beat per cycle.

## Interface
Parameters:
- `SLAVE_NUM`, default 4, number of output channels (must be ≥ 2).
- `DATA_WIDTH`, default 32, tdata width (must match `axis_if`).
- `USER_WIDTH`, default `$clog2(SLAVE_NUM)`+1, tuser width; the extra bit lets an out-of-range index be represented.

Ports:
- Clock and reset:
  - `s_axis.clk`, input, 1 bit, the single clock, shared by all interfaces.
  - `s_axis.arstn`, input, 1 bit, reset; synchronous, active-low, sampled on the rising edge of `s_axis.clk`.
- Input stream `s_axis` (`axis_if`):
  - `tvalid`, `tdata[DATA_WIDTH]`, `tuser[USER_WIDTH]`, `tlast` are inputs.
  - `tready` is an output.
- Output streams `m_axis[SLAVE_NUM]` (`axis_if` array):
  - `tvalid`, `tdata`, `tlast` are outputs; `tuser` is an output equal to the channel index.
  - `tready` is an input.
- `drop_cnt`, output, 16 bits, saturating count of dropped packets.

## Operation
- **Skid buffer:** a 2-entry skid buffer registers the input.
  - `s_axis.tready` is a register equal to "buffer not full".
  - Reset value of `s_axis.tready` is 0; it becomes 1 one cycle after reset is released.
- **Route FSM** operates on the buffer head:
  - `FIRST`: the head is the first beat of a packet.
    - If `tuser < SLAVE_NUM`: latch `dest = tuser`. If the beat transfers and `tlast=0`, go to `FWD`.
    - If `tuser ≥ SLAVE_NUM`: pop the beat immediately and increment `drop_cnt`. If `tlast=0`, go to `DROP`.
  - `FWD`: route every beat to `dest`; `tuser` is ignored. Return to `FIRST` after the beat with `tlast=1` transfers.
  - `DROP`: pop one beat per cycle unconditionally. Return to `FIRST` after the `tlast` beat.
  - A single-beat packet (`tlast=1` on the first beat) never leaves `FIRST`.
- **Output stage:** one register stage per channel, holding `tvalid`, `tdata`, `tlast` and `tuser`.
  - A channel's register loads when it is empty or when its `m_axis[i].tready` is high.
  - Only the selected channel can load in a given cycle.
  - A stalled channel blocks the head of the buffer (head-of-line blocking); this is accepted by design.
- **Invariants:**
  - At most one `m_axis[i].tvalid` rises per cycle.
  - Beat order and packet boundaries are preserved per channel.
  - Registered output values are held stable while `tvalid=1` and `tready=0`.
- **drop_cnt:** increments once per dropped packet, counted on its first beat, and saturates at 16'hFFFF.
- **Reset values:**
  - All `m_axis[i].tvalid` = 0; `tdata`, `tlast` = 0.
  - `drop_cnt` = 0; FSM in `FIRST`; buffer empty.
- **Reset asserted mid-packet:** all in-flight beats are discarded. The first beat after reset is treated as the start of a new packet.

## Timing
- **Latency:** 1 cycle from an `s_axis` handshake to `m_axis[dest].tvalid` when the buffer is empty and the output register is free. A beat held in the skid buffer takes 2 cycles.
- **Throughput:**
  - 1 beat per cycle while the destination keeps `tready=1`.
  - Alternating destinations at packet boundaries also run at 1 beat per cycle, with no bubble.
  - Drops also consume 1 beat per cycle.
- **Backpressure:** `s_axis.tready` falls in the cycle after the buffer fills. No beat is lost when `tvalid` and `tready` deassert together.
- **Dropped packets:** cause no output activity. Counter update: `drop_cnt` changes in the cycle after the first beat is popped.

## Structure
- Shared package `axis_demux_pkg`:
  - `typedef enum logic [1:0] {FIRST, FWD, DROP} route_state_e`.
  - Constant `DROP_CNT_W = 16`.
- Sub-module `axis_skid_buf` holds the 2-entry input register pair and is reusable elsewhere. Routing, the FSM and the output registers live in the top module.

## Test plan
- **Basic routing:** 4-beat packet with `tuser=2`, all outputs ready.
  - Beats appear only on `m_axis[2]`, 1 cycle after each input beat, with `tuser=2` and `tlast` on beat 4.
- **Packet lock:** 3-beat packet whose `tuser` values are 1, 3, 0.
  - All 3 beats go to `m_axis[1]`; channels 0 and 3 stay idle.
- **Drop:** 2-beat packet with `tuser=5`, then a 1-beat packet with `tuser=0`.
  - No output for the dropped packet and `drop_cnt=1`.
  - The next beat appears on `m_axis[0]`.
- **Backpressure:** hold `m_axis[3].tready=0` for 5 cycles during a 6-beat packet with `tuser=3`.
  - `s_axis.tready` falls after 3 beats have been accepted (2 in the buffer, 1 in the output register).
  - Data is held stable; once released, all 6 beats arrive in order with no gaps.
- **Back-to-back packets:** single-beat packets with `tuser` = 0, 1, 2, 3, 0 on consecutive cycles.
  - Each channel shows a 1-cycle `tvalid` pulse, with no bubble between them.
- **Reset mid-packet:** deassert `s_axis.arstn` for 1 cycle during beat 2 of a packet to channel 1; then send a packet with `tuser=3`.
  - All outputs go to 0 in the cycle after reset.
  - The new packet is routed to channel 3, and `drop_cnt=0`.

Source files
------------

// File: rtl/axis_demux_pkg.sv
// Shared types and constants for the AXI-Stream ID demultiplexer.
// Holds the route FSM encoding and the drop counter width/update rule.
package axis_demux_pkg;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    FWD   = 2'd1,
    DROP  = 2'd2
  } route_state_e;

  localparam int DROP_CNT_W = 16;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer with a registered ready; an empty buffer passes the
// input straight to the head so an idle path adds no extra cycle.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             s_valid_i,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             s_ready_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic             ready_q;
  logic             push;
  logic             pop;

  // Kept apart from the next-state logic: m_ready_i is a function of the head.
  assign push      = s_valid_i & ready_q;
  assign m_valid_o = (count_q != 2'd0) | push;
  assign m_data_o  = (count_q != 2'd0) ? ent0_q : s_data_i;
  assign pop       = m_valid_o & m_ready_i;
  assign s_ready_o = ready_q;

  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case (count_q)
      2'd0: begin
        if (push && !pop) begin
          ent0_d  = s_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          ent0_d = s_data_i;
        end else if (push) begin
          ent1_d  = s_data_i;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          ent0_d  = ent1_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      ready_q <= (count_d != 2'd2);
    end
  end

endmodule

// File: rtl/axis_id_demux.sv
// Steers packets of one AXI-Stream to per-channel outputs using tuser of the
// first beat; out-of-range packets are swallowed and counted.
// Handshake: a beat moves on a rising edge where valid and ready are both 1;
// a source holds valid and payload steady until that edge, ready may toggle freely.
module axis_id_demux
  import axis_demux_pkg::*;
#(
  parameter int SLAVE_NUM  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = $clog2(SLAVE_NUM) + 1
) (
  input  logic                                  clk_i,
  input  logic                                  arstn_i,
  input  logic                                  s_axis_tvalid_i,
  input  logic [DATA_WIDTH-1:0]                 s_axis_tdata_i,
  input  logic [USER_WIDTH-1:0]                 s_axis_tuser_i,
  input  logic                                  s_axis_tlast_i,
  output logic                                  s_axis_tready_o,
  output logic [SLAVE_NUM-1:0]                  m_axis_tvalid_o,
  output logic [SLAVE_NUM-1:0][DATA_WIDTH-1:0]  m_axis_tdata_o,
  output logic [SLAVE_NUM-1:0][USER_WIDTH-1:0]  m_axis_tuser_o,
  output logic [SLAVE_NUM-1:0]                  m_axis_tlast_o,
  input  logic [SLAVE_NUM-1:0]                  m_axis_tready_i,
  output logic [DROP_CNT_W-1:0]                 drop_cnt_o,
  output route_state_e                          state_o
);

  localparam int DEST_W = $clog2(SLAVE_NUM);
  localparam int BUF_W  = DATA_WIDTH + USER_WIDTH + 1;

  logic                  head_valid;
  logic [BUF_W-1:0]      head_bus;
  logic [DATA_WIDTH-1:0] head_data;
  logic [USER_WIDTH-1:0] head_user;
  logic                  head_last;
  logic                  pop;
  logic                  fwd;
  logic                  drop_first;
  logic                  in_range;
  logic [DEST_W-1:0]     sel_dest;
  logic [SLAVE_NUM-1:0]  chan_free;
  logic [SLAVE_NUM-1:0]  load;

  route_state_e          state_q;
  logic [DEST_W-1:0]     dest_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  logic [SLAVE_NUM-1:0]                 out_valid_q;
  logic [SLAVE_NUM-1:0]                 out_last_q;
  logic [SLAVE_NUM-1:0][DATA_WIDTH-1:0] out_data_q;

  axis_skid_buf #(
    .WIDTH(BUF_W)
  ) u_skid (
    .clk_i    (clk_i),
    .rstn_i   (arstn_i),
    .s_valid_i(s_axis_tvalid_i),
    .s_data_i ({s_axis_tlast_i, s_axis_tuser_i, s_axis_tdata_i}),
    .s_ready_o(s_axis_tready_o),
    .m_valid_o(head_valid),
    .m_data_o (head_bus),
    .m_ready_i(pop)
  );

  assign {head_last, head_user, head_data} = head_bus;

  always_comb begin
    in_range   = (head_user < USER_WIDTH'(SLAVE_NUM));
    sel_dest   = (state_q == FIRST) ? head_user[DEST_W-1:0] : dest_q;
    chan_free  = ~out_valid_q | m_axis_tready_i;
    fwd        = 1'b0;
    drop_first = 1'b0;
    pop        = 1'b0;
    load       = '0;
    case (state_q)
      FIRST: begin
        if (in_range) begin
          fwd = 1'b1;
          pop = head_valid & chan_free[sel_dest];
        end else begin
          drop_first = head_valid;
          pop        = head_valid;
        end
      end
      FWD: begin
        fwd = 1'b1;
        pop = head_valid & chan_free[sel_dest];
      end
      DROP: pop = head_valid;
      default: pop = 1'b0;
    endcase
    if (fwd && pop) load[sel_dest] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q    <= FIRST;
      dest_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (drop_first) drop_cnt_q <= sat_inc(drop_cnt_q);
      if (pop) begin
        case (state_q)
          FIRST: begin
            dest_q <= sel_dest;
            if (!head_last) state_q <= in_range ? FWD : DROP;
          end
          FWD, DROP: if (head_last) state_q <= FIRST;
          default: state_q <= FIRST;
        endcase
      end
    end
  end

  // A channel that is not loaded empties itself when its sink takes the beat.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      out_valid_q <= '0;
      out_last_q  <= '0;
      out_data_q  <= '0;
    end else begin
      for (int c = 0; c < SLAVE_NUM; c++) begin
        if (load[c]) begin
          out_valid_q[c] <= 1'b1;
          out_data_q[c]  <= head_data;
          out_last_q[c]  <= head_last;
        end else if (m_axis_tready_i[c]) begin
          out_valid_q[c] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < SLAVE_NUM; c++) m_axis_tuser_o[c] = USER_WIDTH'(c);
  end

  assign m_axis_tvalid_o = out_valid_q;
  assign m_axis_tdata_o  = out_data_q;
  assign m_axis_tlast_o  = out_last_q;
  assign drop_cnt_o      = drop_cnt_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_axis_id_demux.sv
// Self-checking bench for axis_id_demux: scenario tasks plus a per-channel
// expected-beat scoreboard filled at input handshakes and drained at outputs.
module tb_axis_id_demux;
  import axis_demux_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int UW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 arstn;
  logic                 s_tvalid;
  logic [DW-1:0]        s_tdata;
  logic [UW-1:0]        s_tuser;
  logic                 s_tlast;
  logic                 s_tready;
  logic [N-1:0]         m_tvalid;
  logic [N-1:0][DW-1:0] m_tdata;
  logic [N-1:0][UW-1:0] m_tuser;
  logic [N-1:0]         m_tlast;
  logic [N-1:0]         m_tready;
  logic [15:0]          drop_cnt;
  route_state_e         state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int cyc      = 0;

  logic [DW:0] exp_q[N][$];
  bit          model_first = 1'b1;
  bit          model_drop  = 1'b0;
  int          model_dest  = 0;
  int          exp_drop    = 0;

  axis_id_demux #(.SLAVE_NUM(N), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk_i          (clk),
    .arstn_i        (arstn),
    .s_axis_tvalid_i(s_tvalid),
    .s_axis_tdata_i (s_tdata),
    .s_axis_tuser_i (s_tuser),
    .s_axis_tlast_i (s_tlast),
    .s_axis_tready_o(s_tready),
    .m_axis_tvalid_o(m_tvalid),
    .m_axis_tdata_o (m_tdata),
    .m_axis_tuser_o (m_tuser),
    .m_axis_tlast_o (m_tlast),
    .m_axis_tready_i(m_tready),
    .drop_cnt_o     (drop_cnt),
    .state_o        (state)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: hold stability while stalled and in-order delivery per channel.
  logic [N-1:0]         prev_stall = '0;
  logic [N-1:0][DW-1:0] prev_data;
  logic [N-1:0]         prev_last;
  always @(negedge clk) begin
    if (!arstn) begin
      prev_stall = '0;
      for (int c = 0; c < N; c++) exp_q[c].delete();
    end else begin
      for (int c = 0; c < N; c++) begin
        if (prev_stall[c]) begin
          n_checks++;
          if (m_tvalid[c] !== 1'b1 || m_tdata[c] !== prev_data[c] || m_tlast[c] !== prev_last[c]) begin
            n_fail++;
            $display("FAIL hold ch%0d: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                     c, m_tvalid[c], m_tdata[c], m_tlast[c], prev_data[c], prev_last[c]);
          end
        end
        if (m_tvalid[c] === 1'b1 && m_tready[c] === 1'b1) begin
          logic [DW:0] exp;
          n_checks++;
          if (exp_q[c].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected ch%0d: got d=%h l=%b, required no beat", c, m_tdata[c], m_tlast[c]);
          end else begin
            exp = exp_q[c].pop_front();
            if ({m_tlast[c], m_tdata[c]} !== exp || m_tuser[c] !== UW'(c)) begin
              n_fail++;
              $display("FAIL scoreboard ch%0d: got l=%b d=%h u=%0d, required l=%b d=%h u=%0d",
                       c, m_tlast[c], m_tdata[c], m_tuser[c], exp[DW], exp[DW-1:0], c);
            end
          end
        end
        prev_stall[c] = m_tvalid[c] & ~m_tready[c];
        prev_data[c]  = m_tdata[c];
        prev_last[c]  = m_tlast[c];
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] data, input int user, input bit last);
    bit done = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tuser  = UW'(user);
    s_tlast  = last;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (s_tready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got tready=0 for 200 cycles, required acceptance of d=%h", data);
    end else begin
      n_acc++;
      if (model_first) begin
        model_drop = (user >= N);
        if (model_drop) exp_drop++;
        else model_dest = user;
      end
      if (!model_drop) exp_q[model_dest].push_back({last, data});
      model_first = last;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (m_tvalid !== '0 || m_tlast !== '0 || m_tdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b l=%b, required all 0", m_tvalid, m_tlast);
    end
    n_checks++;
    if (s_tready !== 1'b0 || drop_cnt !== 16'd0 || state !== FIRST) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b drop=%0d st=%0d, required 0 0 0", s_tready, drop_cnt, state);
    end
    arstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_early: got %b, required 0", s_tready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, required 1", s_tready);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      send_beat(32'hA000_0000 + 32'(i), 2, i == 3);
      n_checks++;
      if (m_tvalid !== 4'b0100 || m_tdata[2] !== 32'hA000_0000 + 32'(i) || m_tlast[2] !== (i == 3)
          || m_tuser[2] !== 3'd2) begin
        n_fail++;
        $display("FAIL basic beat%0d: got v=%b d=%h l=%b u=%0d, required v=0100 d=%h l=%b u=2",
                 i, m_tvalid, m_tdata[2], m_tlast[2], m_tuser[2], 32'hA000_0000 + 32'(i), i == 3);
      end
    end
    idle(3);
  endtask

  task automatic test_lock();
    int users[3] = '{1, 3, 0};
    for (int i = 0; i < 3; i++) begin
      send_beat(32'hC000_0000 + 32'(i), users[i], i == 2);
      n_checks++;
      if (m_tvalid !== 4'b0010 || m_tdata[1] !== 32'hC000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL lock beat%0d: got v=%b d=%h, required v=0010 d=%h",
                 i, m_tvalid, m_tdata[1], 32'hC000_0000 + 32'(i));
      end
    end
    idle(3);
  endtask

  task automatic test_drop();
    for (int i = 0; i < 2; i++) begin
      send_beat(32'hD000_0000 + 32'(i), 5, i == 1);
      n_checks++;
      if (m_tvalid !== 4'b0000 || drop_cnt !== 16'd1) begin
        n_fail++;
        $display("FAIL drop beat%0d: got v=%b cnt=%0d, required v=0000 cnt=1", i, m_tvalid, drop_cnt);
      end
    end
    send_beat(32'hD000_00FF, 0, 1'b1);
    n_checks++;
    if (m_tvalid !== 4'b0001 || m_tdata[0] !== 32'hD000_00FF || drop_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL after_drop: got v=%b d=%h cnt=%0d, required v=0001 d=d00000ff cnt=1",
               m_tvalid, m_tdata[0], drop_cnt);
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    m_tready = 4'b0111;
    n_acc    = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(32'hB000_0000 + 32'(i), 3, i == 5);
      end
      begin
        for (int t = 0; t < 50 && n_acc < 1; t++) @(negedge clk);
        for (int s = 0; s < 5; s++) begin
          n_checks++;
          if (m_tvalid[3] !== 1'b1 || m_tdata[3] !== 32'hB000_0000) begin
            n_fail++;
            $display("FAIL bp_stall%0d: got v=%b d=%h, required v=1 d=b0000000", s, m_tvalid[3], m_tdata[3]);
          end
          if (s >= 2) begin
            n_checks++;
            if (s_tready !== 1'b0 || n_acc !== 3) begin
              n_fail++;
              $display("FAIL bp_ready%0d: got rdy=%b accepted=%0d, required rdy=0 accepted=3", s, s_tready, n_acc);
            end
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        m_tready = 4'b1111;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          n_checks++;
          if (m_tvalid[3] !== 1'b1 || m_tdata[3] !== 32'hB000_0000 + 32'(j)) begin
            n_fail++;
            $display("FAIL bp_drain%0d: got v=%b d=%h, required v=1 d=%h",
                     j, m_tvalid[3], m_tdata[3], 32'hB000_0000 + 32'(j));
          end
        end
      end
    join
    idle(3);
  endtask

  task automatic test_back_to_back();
    int users[5] = '{0, 1, 2, 3, 0};
    int t0;
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      send_beat(32'hE000_0000 + 32'(i), users[i], 1'b1);
      n_checks++;
      if (m_tvalid !== (4'b0001 << users[i]) || m_tdata[users[i]] !== 32'hE000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL b2b%0d: got v=%b d=%h, required v=%b d=%h", i, m_tvalid, m_tdata[users[i]],
                 4'b0001 << users[i], 32'hE000_0000 + 32'(i));
      end
    end
    n_checks++;
    if (cyc - t0 !== 5) begin
      n_fail++;
      $display("FAIL b2b_rate: got %0d cycles, required 5", cyc - t0);
    end
    idle(3);
  endtask

  task automatic test_random();
    bit stop = 1'b0;
    fork
      begin
        for (int p = 0; p < 16; p++) begin
          int u   = $urandom_range(0, 5);
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) send_beat($urandom, u, b == len - 1);
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          m_tready = 4'($urandom_range(0, 15));
        end
      end
    join
    m_tready = 4'b1111;
    for (int t = 0; t < 20; t++) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d beats missing, required 0",
               exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
    end
    n_checks++;
    if (drop_cnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL rand_drop_cnt: got %0d, required %0d", drop_cnt, exp_drop);
    end
  endtask

  task automatic test_reset_mid();
    send_beat(32'hF000_0000, 1, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'hF000_0001;
    s_tuser  = 3'd1;
    s_tlast  = 1'b0;
    arstn    = 1'b0;
    @(posedge clk);
    #1;
    arstn       = 1'b1;
    s_tvalid    = 1'b0;
    model_first = 1'b1;
    exp_drop    = 0;
    n_checks++;
    if (m_tvalid !== '0 || m_tdata[1] !== '0 || drop_cnt !== 16'd0 || s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b d=%h cnt=%0d rdy=%b, required all 0",
               m_tvalid, m_tdata[1], drop_cnt, s_tready);
    end
    for (int i = 0; i < 2; i++) begin
      send_beat(32'h9000_0000 + 32'(i), 3, i == 1);
      n_checks++;
      if (m_tvalid !== 4'b1000 || m_tdata[3] !== 32'h9000_0000 + 32'(i) || drop_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL post_reset%0d: got v=%b d=%h cnt=%0d, required v=1000 d=%h cnt=0",
                 i, m_tvalid, m_tdata[3], drop_cnt, 32'h9000_0000 + 32'(i));
      end
    end
    idle(3);
  endtask

  initial begin
    arstn    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = '0;
    s_tlast  = 1'b0;
    m_tready = 4'b1111;
    test_reset();
    test_basic();
    test_lock();
    test_drop();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
